// File: rtl/dvi_tmds_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dvi_tmds_pkg: TMDS control tokens, align FSM states, word decode
// Revision: 1.0
// ------------------------------------------------------------------
package dvi_tmds_pkg;

  localparam logic [9:0] c_token_c00 = 10'h354;
  localparam logic [9:0] c_token_c01 = 10'h0AB;
  localparam logic [9:0] c_token_c10 = 10'h154;
  localparam logic [9:0] c_token_c11 = 10'h2AB;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_t;

  function automatic logic is_token(input logic [9:0] q);
    return (q == c_token_c00) || (q == c_token_c01) ||
           (q == c_token_c10) || (q == c_token_c11);
  endfunction

  function automatic logic [1:0] token_ctrl(input logic [9:0] q);
    logic [1:0] c;
    case (q)
      c_token_c01: c = 2'b01;
      c_token_c10: c = 2'b10;
      c_token_c11: c = 2'b11;
      default:     c = 2'b00;
    endcase
    return c;
  endfunction

  // q[9] flags an inverted payload; q[8] selects XOR (1) or XNOR (0) chaining
  function automatic logic [7:0] tmds_decode_data(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] r;
    d    = q[9] ? ~q[7:0] : q[7:0];
    r    = '0;
    r[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvi_rx_word_align.sv
`default_nettype none
// ------------------------------------------------------------------
// dvi_rx_word_align: bit-offset search and token-run lock tracking
// Revision: 1.0
// ------------------------------------------------------------------
module dvi_rx_word_align #(
  parameter int TOKEN_RUN    = 8,
  parameter int SEARCH_DWELL = 2048,
  parameter int LOSS_TIMEOUT = 8192
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic [9:0] raw,
  output logic [9:0] word,
  output logic       locked,
  output logic [3:0] offset,
  output logic       lock_lost
);
  import dvi_tmds_pkg::*;

  localparam int TW = $clog2(TOKEN_RUN + 1);
  localparam int DW = (SEARCH_DWELL > 1) ? $clog2(SEARCH_DWELL) : 1;
  localparam int LW = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [TW-1:0] c_token_run    = TW'(TOKEN_RUN);
  localparam logic [DW-1:0] c_dwell_last   = DW'(SEARCH_DWELL - 1);
  localparam logic [LW-1:0] c_loss_timeout = LW'(LOSS_TIMEOUT);

  align_state_t  r_state, w_state_nxt;
  logic [9:0]    r_raw_d;
  logic [19:0]   w_window;
  logic [9:0]    w_aligned;
  logic          w_is_tok;
  logic [3:0]    w_offset_nxt;
  logic [TW-1:0] r_tok_cnt, w_tok_nxt;
  logic [DW-1:0] r_dwell, w_dwell_nxt;
  logic [LW-1:0] r_loss, w_loss_nxt;
  logic [1:0]    r_holdoff, w_holdoff_nxt;

  assign w_window  = {raw, r_raw_d} >> offset;
  assign w_aligned = w_window[9:0];
  assign w_is_tok  = is_token(word);
  assign locked    = (r_state == ST_LOCKED);
  assign lock_lost = (r_state == ST_LOCKED) && (r_loss == c_loss_timeout);

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      r_raw_d   <= '0;
      word      <= '0;
      r_state   <= ST_SEARCH;
      offset    <= '0;
      r_tok_cnt <= '0;
      r_dwell   <= '0;
      r_loss    <= '0;
      r_holdoff <= '0;
    end else begin
      r_raw_d   <= raw;
      word      <= w_aligned;
      r_state   <= w_state_nxt;
      offset    <= w_offset_nxt;
      r_tok_cnt <= w_tok_nxt;
      r_dwell   <= w_dwell_nxt;
      r_loss    <= w_loss_nxt;
      r_holdoff <= w_holdoff_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_offset_nxt  = offset;
    w_tok_nxt     = r_tok_cnt;
    w_dwell_nxt   = '0;
    w_loss_nxt    = '0;
    w_holdoff_nxt = r_holdoff;
    case (r_state)
      ST_SEARCH: begin
        w_dwell_nxt = r_dwell + DW'(1);
        // stage-1 words straddling an offset change are not trusted
        if (r_holdoff != 2'd0) begin
          w_holdoff_nxt = r_holdoff - 2'd1;
          w_tok_nxt     = '0;
        end else if (!w_is_tok) begin
          w_tok_nxt = '0;
        end else if (r_tok_cnt != c_token_run) begin
          w_tok_nxt = r_tok_cnt + TW'(1);
        end
        // a completed run wins over a dwell expiring in the same cycle
        if (r_tok_cnt == c_token_run) begin
          w_state_nxt   = ST_LOCKED;
          w_tok_nxt     = '0;
          w_dwell_nxt   = '0;
          w_holdoff_nxt = '0;
        end else if (r_dwell == c_dwell_last) begin
          w_offset_nxt  = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          w_dwell_nxt   = '0;
          w_tok_nxt     = '0;
          w_holdoff_nxt = 2'd2;
        end
      end
      ST_LOCKED: begin
        if (r_loss == c_loss_timeout) begin
          w_state_nxt = ST_SEARCH;
          w_tok_nxt   = '0;
        end else if (!w_is_tok) begin
          w_loss_nxt = r_loss + LW'(1);
        end
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dvi_rx_tmds_dec.sv
`default_nettype none
// ------------------------------------------------------------------
// dvi_rx_tmds_dec: DVI TMDS channel receiver (word align + decode)
// Revision: 1.0
// ------------------------------------------------------------------
module dvi_rx_tmds_dec #(
  parameter int TOKEN_RUN    = 8,
  parameter int SEARCH_DWELL = 2048,
  parameter int LOSS_TIMEOUT = 8192
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic [9:0] raw,
  output logic       den,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic [3:0] offset,
  output logic       lock_lost
);
  import dvi_tmds_pkg::*;

  logic [9:0] w_stage1_word;
  logic       w_den_nxt;
  logic [7:0] w_data_nxt;
  logic [1:0] w_ctrl_nxt;

  dvi_rx_word_align #(
    .TOKEN_RUN   (TOKEN_RUN),
    .SEARCH_DWELL(SEARCH_DWELL),
    .LOSS_TIMEOUT(LOSS_TIMEOUT)
  ) u_align (
    .pixel_clock(pixel_clock),
    .reset      (reset),
    .raw        (raw),
    .word       (w_stage1_word),
    .locked     (locked),
    .offset     (offset),
    .lock_lost  (lock_lost)
  );

  // data words keep the control value of the most recent token
  always_comb begin
    w_den_nxt  = 1'b0;
    w_data_nxt = '0;
    w_ctrl_nxt = ctrl;
    if (!locked) begin
      w_ctrl_nxt = '0;
    end else if (is_token(w_stage1_word)) begin
      w_ctrl_nxt = token_ctrl(w_stage1_word);
    end else begin
      w_den_nxt  = 1'b1;
      w_data_nxt = tmds_decode_data(w_stage1_word);
    end
  end

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      den  <= 1'b0;
      data <= '0;
      ctrl <= '0;
    end else begin
      den  <= w_den_nxt;
      data <= w_data_nxt;
      ctrl <= w_ctrl_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dvi_rx_tmds_dec.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// tb_dvi_rx_tmds_dec: vector table + scoreboard bench for the TMDS rx
// Revision: 1.0
// ------------------------------------------------------------------
module tb_dvi_rx_tmds_dec;

  localparam int TOKEN_RUN    = 8;
  localparam int SEARCH_DWELL = 16;
  localparam int LOSS_TIMEOUT = 64;
  // raw sampled -> raw_d -> stage 1 -> stage 2
  localparam int LAT          = 3;
  localparam int NVEC         = 15;

  logic       pixel_clock = 1'b0;
  logic       reset       = 1'b0;
  logic [9:0] raw         = '0;
  logic       den;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] offset;
  logic       lock_lost;

  dvi_rx_tmds_dec #(
    .TOKEN_RUN   (TOKEN_RUN),
    .SEARCH_DWELL(SEARCH_DWELL),
    .LOSS_TIMEOUT(LOSS_TIMEOUT)
  ) dut (
    .pixel_clock(pixel_clock),
    .reset      (reset),
    .raw        (raw),
    .den        (den),
    .data       (data),
    .ctrl       (ctrl),
    .locked     (locked),
    .offset     (offset),
    .lock_lost  (lock_lost)
  );

  always #5 pixel_clock = ~pixel_clock;

  int cyc = 0;
  always @(posedge pixel_clock) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [9:0] raw;
    logic       den;
    logic [7:0] data;
    logic [1:0] ctrl;
  } vec_t;

  typedef struct {
    int         due;
    logic       den;
    logic [7:0] data;
    logic [1:0] ctrl;
    int         idx;
  } exp_t;

  vec_t tbl[NVEC];
  exp_t sbq[$];

  // word whose bit i lands at stream position (i + o) mod 10
  function automatic logic [9:0] place_at(input logic [9:0] t, input int o);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[(i + o) % 10] = t[i];
    return r;
  endfunction

  always @(negedge pixel_clock) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      check($sformatf("vec%0d", e.idx), 32'({den, data, ctrl}), 32'({e.den, e.data, e.ctrl}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, required finish before 100000 ns");
    $fatal(1);
  end

  initial begin
    int   k;
    int   t_last;
    int   lost_at;
    int   pulses;
    int   prev;
    int   changes;
    exp_t e;

    // A5 encodings: XOR/q9=0 0x163, XOR/q9=1 0x39C, XNOR/q9=0 0x0C9, XNOR/q9=1 0x236
    tbl[0]  = '{10'h354, 1'b0, 8'h00, 2'b00};
    tbl[1]  = '{10'h163, 1'b1, 8'hA5, 2'b00};
    tbl[2]  = '{10'h39C, 1'b1, 8'hA5, 2'b00};
    tbl[3]  = '{10'h2AB, 1'b0, 8'h00, 2'b11};
    tbl[4]  = '{10'h0C9, 1'b1, 8'hA5, 2'b11};
    tbl[5]  = '{10'h236, 1'b1, 8'hA5, 2'b11};
    tbl[6]  = '{10'h0AB, 1'b0, 8'h00, 2'b01};
    tbl[7]  = '{10'h000, 1'b1, 8'hFE, 2'b01};
    tbl[8]  = '{10'h154, 1'b0, 8'h00, 2'b10};
    tbl[9]  = '{10'h100, 1'b1, 8'h00, 2'b10};
    tbl[10] = '{10'h3FF, 1'b1, 8'h00, 2'b10};
    tbl[11] = '{10'h1FF, 1'b1, 8'h01, 2'b10};
    tbl[12] = '{10'h0FF, 1'b1, 8'hFF, 2'b10};
    tbl[13] = '{10'h2FF, 1'b1, 8'hFE, 2'b10};
    tbl[14] = '{10'h354, 1'b0, 8'h00, 2'b00};

    // reset state
    repeat (3) @(negedge pixel_clock);
    check("rst_outputs", 32'({den, data, ctrl}), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_offset", 32'(offset), 32'h0);
    check("rst_lock_lost", 32'(lock_lost), 32'h0);

    // token run at offset 0: first token in stage 1 at k=2, locked at k=11
    @(negedge pixel_clock);
    reset = 1'b1;
    raw   = 10'h354;
    for (int j = 1; j <= 11; j++) begin
      @(negedge pixel_clock);
      if (j == 10) check("lock_not_yet_k10", 32'(locked), 32'h0);
      if (j == 11) check("lock_at_k11", 32'(locked), 32'h1);
      raw = 10'h354;
    end

    // decode table through the scoreboard
    t_last = 0;
    for (int i = 0; i < NVEC; i++) begin
      @(negedge pixel_clock);
      raw    = tbl[i].raw;
      e.due  = cyc + LAT;
      e.den  = tbl[i].den;
      e.data = tbl[i].data;
      e.ctrl = tbl[i].ctrl;
      e.idx  = i;
      sbq.push_back(e);
      t_last = cyc;
    end
    for (int w = 0; w < 10 && sbq.size() != 0; w++) begin
      @(negedge pixel_clock);
      raw = 10'h163;
    end
    check("scoreboard_drained", 32'(sbq.size()), 32'h0);
    check("still_locked", 32'(locked), 32'h1);

    // loss of lock: last token reaches stage 1 at t_last+2, timer saturates 64 later
    pulses  = 0;
    lost_at = -1;
    for (int w = 0; w < 100; w++) begin
      @(negedge pixel_clock);
      raw = 10'h163;
      if (lock_lost) begin
        pulses++;
        if (lost_at < 0) begin
          lost_at = cyc;
          check("locked_during_pulse", 32'(locked), 32'h1);
        end
      end
      if (lost_at >= 0 && cyc == lost_at + 2) begin
        check("unlocked_after_loss", 32'(locked), 32'h0);
        check("offset_kept_after_loss", 32'(offset), 32'h0);
        check("outputs_zeroed_after_loss", 32'({den, data, ctrl}), 32'h0);
      end
    end
    check("lock_lost_pulses", 32'(pulses), 32'h1);
    check("loss_latency", 32'(lost_at - t_last), 32'(LAT + LOSS_TIMEOUT));

    // lock on C1C0=11 tokens, then async reset mid-lock
    @(negedge pixel_clock);
    reset = 1'b0;
    @(negedge pixel_clock);
    reset = 1'b1;
    raw   = 10'h2AB;
    k = 0;
    while (!locked && k < 40) begin
      @(negedge pixel_clock);
      k++;
    end
    check("lock_2ab_latency", 32'(k), 32'd11);
    repeat (3) @(negedge pixel_clock);
    check("ctrl11_before_reset", 32'({den, data, ctrl}), 32'h003);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", 32'({den, data, ctrl, locked, lock_lost, offset}), 32'h0);
    @(negedge pixel_clock);
    reset = 1'b1;
    raw   = 10'h354;
    k = 0;
    while (!locked && k < 40) begin
      @(negedge pixel_clock);
      k++;
    end
    check("relock_latency", 32'(k), 32'd11);
    check("relock_offset", 32'(offset), 32'h0);

    // stream with true offset 7: search must step 0..7 and stay there
    @(negedge pixel_clock);
    reset = 1'b0;
    @(negedge pixel_clock);
    reset = 1'b1;
    raw   = place_at(10'h354, 7);
    prev  = 0;
    for (int w = 0; w < 300 && !locked; w++) begin
      @(negedge pixel_clock);
      if (int'(offset) != prev) begin
        check("offset_step", 32'(offset), 32'((prev + 1) % 10));
        prev = int'(offset);
      end
    end
    check("rot_locked", 32'(locked), 32'h1);
    check("rot_offset", 32'(offset), 32'd7);
    changes = 0;
    for (int w = 0; w < 80; w++) begin
      @(negedge pixel_clock);
      if (offset != 4'd7 || !locked) changes++;
    end
    check("rot_stable", 32'(changes), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
